// File: rtl/rpi_accel_pkg.sv
// Shared types and constants for the RaspberryPi_Accelerator receive path.
package rpi_accel_pkg;

  localparam int unsigned INST_WIDTH = 80;

  typedef enum logic [7:0] {
    ST_READY        = 8'h00,
    ST_BUSY         = 8'h01,
    ST_DONE         = 8'h02,
    ST_INVALID      = 8'hE1,
    ST_SHORT        = 8'hE2,
    ST_GAP_TIMEOUT  = 8'hE3,
    ST_DONE_TIMEOUT = 8'hE4
  } status_t;

  typedef enum logic [2:0] {
    COLLECT,
    CHECK,
    HOLD,
    DISPATCH,
    WAIT_DONE
  } rx_state_t;

endpackage

// File: rtl/rpi_inst_receiver_timeout.sv
// Cycle counter that flags the LIMIT-th consecutive enabled cycle.
module timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  // Count enabled cycles; clear takes precedence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     count <= '0;
    else if (clear)   count <= '0;
    else if (enable)  count <= count + W'(1);
  end

  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/rpi_inst_receiver.sv
// Assembles SPI bytes into instruction frames, validates and dispatches them
// to task_manager, and tracks each job to completion with a status code.
module rpi_inst_receiver
  import rpi_accel_pkg::*;
#(
  parameter int unsigned N            = INST_WIDTH,
  parameter int unsigned GAP_TIMEOUT  = 1024,
  parameter int unsigned DONE_TIMEOUT = 1048576
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         frame_active,
  output logic [N-1:0] RPi_inst,
  output logic         execute_task,
  input  logic         inst_valid,
  input  logic         job_done,
  output logic [7:0]   status,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned NBYTES = N / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);

  rx_state_t      state, state_nxt;
  logic [CW-1:0]  byte_cnt;
  // Only the first NBYTES-1 bytes need storing; the last byte joins on latch.
  logic [N-9:0]   shift_q;
  status_t        status_q;
  logic           overrun_q, seen_low, fa_q;
  logic           in_collect, frame_fall, last_byte;
  logic           gap_en, gap_expired, done_en, done_expired;

  assign in_collect = (state == COLLECT);
  assign frame_fall = fa_q && !frame_active;
  assign last_byte  = (byte_cnt == CW'(NBYTES - 1));
  assign gap_en     = in_collect && (byte_cnt != '0) && !rx_valid;
  assign done_en    = (state == WAIT_DONE);

  timeout_counter #(.LIMIT(GAP_TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!gap_en),
    .enable  (gap_en),
    .expired (gap_expired)
  );

  timeout_counter #(.LIMIT(DONE_TIMEOUT)) u_done_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!done_en),
    .enable  (done_en),
    .expired (done_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT:   if (rx_valid && last_byte) state_nxt = CHECK;
      CHECK:     if (!inst_valid)   state_nxt = COLLECT;
                 else if (job_done) state_nxt = DISPATCH;
                 else               state_nxt = HOLD;
      HOLD:      if (job_done) state_nxt = DISPATCH;
      DISPATCH:  state_nxt = WAIT_DONE;
      WAIT_DONE: if ((seen_low && job_done) || done_expired) state_nxt = COLLECT;
      default:   state_nxt = COLLECT;
    endcase
  end

  // Frame assembly, status reporting and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fa_q      <= 1'b0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      RPi_inst  <= '0;
      status_q  <= ST_READY;
      overrun_q <= 1'b0;
      seen_low  <= 1'b0;
    end else begin
      fa_q <= frame_active;
      case (state)
        COLLECT: begin
          // An accepted byte outranks a chip-select drop or gap expiry.
          if (rx_valid) begin
            shift_q <= {shift_q[N-17:0], rx_byte};
            if (byte_cnt == '0) begin
              status_q  <= ST_READY;
              overrun_q <= 1'b0;
            end
            if (last_byte) begin
              RPi_inst <= {shift_q, rx_byte};
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end else if ((byte_cnt != '0) && frame_fall) begin
            byte_cnt <= '0;
            status_q <= ST_SHORT;
          end else if (gap_expired) begin
            byte_cnt <= '0;
            status_q <= ST_GAP_TIMEOUT;
          end
        end
        CHECK:    status_q <= inst_valid ? ST_BUSY : ST_INVALID;
        DISPATCH: seen_low <= 1'b0;
        WAIT_DONE: begin
          if (!job_done) seen_low <= 1'b1;
          if (seen_low && job_done) status_q <= ST_DONE;
          else if (done_expired)    status_q <= ST_DONE_TIMEOUT;
        end
        default: ;
      endcase
      if (!in_collect && rx_valid) overrun_q <= 1'b1;
    end
  end

  assign execute_task = (state == DISPATCH);
  assign busy         = !in_collect;
  assign status       = status_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_rpi_inst_receiver.sv
// Scoreboard bench for rpi_inst_receiver: frame-level model predicts the
// sequence of status changes and dispatch pulses; a monitor checks them.
module tb_rpi_inst_receiver;
  import rpi_accel_pkg::*;

  localparam int unsigned N   = 80;
  localparam int unsigned NB  = N / 8;
  localparam int unsigned GAP = 1024;
  localparam int unsigned DTO = 300;
  localparam int unsigned W   = N + 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_valid = 1'b0;
  logic         frame_active = 1'b0;
  logic [N-1:0] RPi_inst;
  logic         execute_task;
  logic         inst_valid, job_done;
  logic [7:0]   status;
  logic         busy, overrun;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  rpi_inst_receiver #(.N(N), .GAP_TIMEOUT(GAP), .DONE_TIMEOUT(DTO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .frame_active (frame_active),
    .RPi_inst     (RPi_inst),
    .execute_task (execute_task),
    .inst_valid   (inst_valid),
    .job_done     (job_done),
    .status       (status),
    .busy         (busy),
    .overrun      (overrun)
  );

  // task_manager stand-in: opcode nibble 0x1 is illegal; jobs last job_len cycles.
  int unsigned job_left = 0;
  int unsigned job_len  = 10;
  logic        hold     = 1'b0;
  assign inst_valid = (RPi_inst[N-1 -: 4] != 4'h1);
  assign job_done   = (job_left == 0) && !hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)              job_left <= 0;
    else if (execute_task)     job_left <= job_len;
    else if (job_left != 0)    job_left <= job_left - 1;
  end

  typedef struct {
    logic         is_exec;
    logic [N-1:0] data;
  } ev_t;

  ev_t          exp_q[$];
  ev_t          mon_e;
  logic [7:0]   exp_status = 8'h00;
  logic [N-1:0] last_word  = '0;
  logic [7:0]   fb [NB];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_status(input logic [7:0] s);
    ev_t e;
    if (s != exp_status) begin
      e.is_exec = 1'b0;
      e.data    = N'(s);
      exp_q.push_back(e);
    end
    exp_status = s;
  endtask

  task automatic push_exec(input logic [N-1:0] w);
    ev_t e;
    e.is_exec = 1'b1;
    e.data    = w;
    exp_q.push_back(e);
  endtask

  function automatic logic [N-1:0] frame_word();
    logic [N-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < NB; i++) w[N-1-8*i -: 8] = fb[i];
    return w;
  endfunction

  // Frame-level reference: what the receiver must report for n bytes of fb.
  task automatic expect_frame(input int unsigned n, input int unsigned jl);
    logic [N-1:0] w;
    push_status(8'h00);
    if (n < NB) begin
      push_status(8'hE2);
    end else begin
      w = frame_word();
      last_word = w;
      if (w[N-1 -: 4] == 4'h1) begin
        push_status(8'hE1);
      end else begin
        push_status(8'h01);
        push_exec(w);
        push_status((jl + 10 < DTO) ? 8'h02 : 8'hE4);
      end
    end
  endtask

  // Monitor: every status change and every execute_task cycle is an event.
  logic [7:0]  prev_status = 8'h00;
  int unsigned exec_count  = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_status = status;
    end else begin
      if (status !== prev_status) begin
        prev_status = status;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_status: got %h expected no event", status);
        end else begin
          mon_e = exp_q.pop_front();
          check("status_event", {1'b0, N'(status)}, {mon_e.is_exec, mon_e.data});
        end
      end
      if (execute_task) begin
        exec_count++;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_exec: got pulse with %h expected no event", RPi_inst);
        end else begin
          mon_e = exp_q.pop_front();
          check("exec_event", {1'b1, RPi_inst}, {mon_e.is_exec, mon_e.data});
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int unsigned n, input logic drop);
    int unsigned g;
    frame_active = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(fb[i]);
      if (i + 1 < n) begin
        g = $urandom_range(0, 3);
        if (g != 0) tick(g);
      end
    end
    if (drop) frame_active = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while ((busy || job_left != 0) && k < 3000) begin
      tick(1);
      k++;
    end
    check("idle_reached", W'(busy || job_left != 0), W'(0));
    tick(2);
    check("sb_drained", W'(exp_q.size()), W'(0));
  endtask

  task automatic rand_frame(input logic valid);
    for (int unsigned i = 0; i < NB; i++) fb[i] = 8'($urandom);
    if (!valid)                  fb[0][7:4] = 4'h1;
    else if (fb[0][7:4] == 4'h1) fb[0][7:4] = 4'h9;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned ec, kind, n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst",    W'(RPi_inst),     W'(0));
    check("rst_status",  W'(status),       W'(0));
    check("rst_busy",    W'(busy),         W'(0));
    check("rst_overrun", W'(overrun),      W'(0));
    check("rst_exec",    W'(execute_task), W'(0));
    reset_n = 1'b1;
    tick(1);

    // 1: directed valid frame
    fb[0] = 8'hFF;
    for (int unsigned i = 1; i < NB - 1; i++) fb[i] = 8'h00;
    fb[NB-1] = 8'h2A;
    job_len = 8;
    ec = exec_count;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    check("t1_inst", W'(RPi_inst), W'(80'hFF00000000000000002A));
    wait_idle();
    check("t1_one_pulse", W'(exec_count - ec), W'(1));

    // 2: illegal opcode
    rand_frame(1'b0);
    fb[0] = 8'h10;
    ec = exec_count;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    check("t2_busy_check", W'(busy), W'(1));
    tick(1);
    check("t2_busy_back", W'(busy), W'(0));
    check("t2_status", W'(status), W'(8'hE1));
    wait_idle();
    check("t2_no_pulse", W'(exec_count - ec), W'(0));

    // 3: short frame, then a full one
    rand_frame(1'b1);
    expect_frame(4, job_len);
    send_frame(4, 1'b1);
    tick(2);
    check("t3_status", W'(status), W'(8'hE2));
    check("t3_inst_kept", W'(RPi_inst), W'(last_word));
    wait_idle();
    rand_frame(1'b1);
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    wait_idle();
    check("t3_next_inst", W'(RPi_inst), W'(last_word));

    // 4: inter-byte gap timeout, next byte starts a fresh frame
    rand_frame(1'b1);
    push_status(8'h00);
    push_status(8'hE3);
    send_frame(3, 1'b0);
    tick(1000);
    check("t4_before_gap", W'(status), W'(8'h00));
    tick(40);
    check("t4_gap", W'(status), W'(8'hE3));
    rand_frame(1'b1);
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    check("t4_realigned", W'(RPi_inst), W'(frame_word()));
    wait_idle();

    // 5: HOLD while task_manager busy, then overrun in WAIT_DONE
    rand_frame(1'b1);
    job_len = 30;
    hold = 1'b1;
    ec = exec_count;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    tick(50);
    check("t5_hold_no_pulse", W'(exec_count - ec), W'(0));
    check("t5_hold_busy", W'(busy), W'(1));
    check("t5_hold_status", W'(status), W'(8'h01));
    hold = 1'b0;
    tick(1);
    check("t5_pulse", W'(execute_task), W'(1));
    tick(5);
    send_byte(8'h55);
    check("t5_overrun", W'(overrun), W'(1));
    wait_idle();
    rand_frame(1'b1);
    job_len = 12;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    check("t5_overrun_clr", W'(overrun), W'(0));
    check("t5_byte_dropped", W'(RPi_inst), W'(frame_word()));
    wait_idle();

    // Done timeout
    rand_frame(1'b1);
    job_len = 400;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    wait_idle();
    check("done_timeout", W'(status), W'(8'hE4));

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      kind    = $urandom_range(0, 3);
      job_len = $urandom_range(2, 40);
      rand_frame(kind != 1);
      n = (kind == 0) ? $urandom_range(1, NB - 1) : NB;
      expect_frame(n, job_len);
      send_frame(n, 1'b1);
      wait_idle();
      check("rnd_inst", W'(RPi_inst), W'(last_word));
    end

    // 6: reset during WAIT_DONE
    rand_frame(1'b1);
    job_len = 60;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    tick(15);
    exp_q.delete();
    exp_status = 8'h00;
    last_word  = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("r6_exec",    W'(execute_task), W'(0));
    check("r6_status",  W'(status),       W'(0));
    check("r6_busy",    W'(busy),         W'(0));
    check("r6_inst",    W'(RPi_inst),     W'(0));
    check("r6_overrun", W'(overrun),      W'(0));
    tick(3);
    reset_n = 1'b1;
    ec = exec_count;
    tick(20);
    check("r6_no_glitch", W'(exec_count - ec), W'(0));
    check("r6_idle", W'(busy), W'(0));
    rand_frame(1'b1);
    job_len = 5;
    expect_frame(NB, job_len);
    send_frame(NB, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rpi_inst_receiver.md
Name: rpi_inst_receiver

Overview:
- Upstream stage of task_manager in the RaspberryPi_Accelerator design.
- Takes the byte stream already deserialised by the SPI slave and assembles N-bit instruction frames, MSB byte first.
- Presents each completed frame on RPi_inst and checks it against task_manager's inst_valid and job_done.
- Issues a single-cycle execute_task, tracks the job to completion, and reports an 8-bit status code for SPI readback.

Parameters:
N, 80, instruction width in bits; must be a multiple of 8; NBYTES = N/8.
GAP_TIMEOUT, 1024, maximum clk cycles allowed between bytes inside one frame.
DONE_TIMEOUT, 1048576, maximum clk cycles to wait for job_done after dispatch.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
rx_byte  input  8  byte from the SPI slave.
rx_valid  input  1  single-cycle strobe; rx_byte is valid in that cycle.
frame_active  input  1  high while SPI chip-select is asserted.
RPi_inst  output  N  assembled instruction to task_manager.
execute_task  output  1  one-cycle dispatch pulse to task_manager.
inst_valid  input  1  from task_manager; combinational in RPi_inst.
job_done  input  1  from task_manager; high when idle.
status  output  8  current status code.
busy  output  1  high in every state except COLLECT.
overrun  output  1  sticky; a byte arrived while not in COLLECT.

Behaviour:
- Reset: state=COLLECT, byte_cnt=0, shift register=0, RPi_inst=0, execute_task=0, status=0x00 (READY), busy=0, overrun=0, both timers=0.
- Status codes: 0x00 READY, 0x01 BUSY, 0x02 DONE, 0xE1 INVALID, 0xE2 SHORT, 0xE3 GAP_TIMEOUT, 0xE4 DONE_TIMEOUT.
- COLLECT:
  - On rx_valid: shift <= {shift[N-9:0], rx_byte}; byte_cnt++; gap timer cleared.
  - On the byte that makes byte_cnt == NBYTES: RPi_inst <= completed word, byte_cnt <= 0, go to CHECK.
  - The byte index is not checked against frame_active rising; the first byte starts the frame.
- Short frame: frame_active falls while 0 < byte_cnt < NBYTES -> byte_cnt <= 0, status=0xE2, stay in COLLECT.
- Gap timeout: gap timer counts while byte_cnt > 0 and no rx_valid. On reaching GAP_TIMEOUT -> byte_cnt <= 0, status=0xE3.
- Priority within a cycle: rx_valid wins over frame_active fall and over timeout in the same cycle.
- CHECK (one cycle, lets inst_valid settle):
  - !inst_valid -> status=0xE1, return to COLLECT.
  - inst_valid & job_done -> DISPATCH, status=0x01.
  - inst_valid & !job_done -> HOLD, status=0x01.
- HOLD: wait for job_done=1, then go to DISPATCH. No timeout in HOLD.
- DISPATCH: execute_task=1 for exactly one cycle, then go to WAIT_DONE with the done timer cleared.
- WAIT_DONE:
  - Must observe job_done=0 at least once (seen_low flag); after that, job_done=1 -> status=0x02, go to COLLECT.
  - If the done timer reaches DONE_TIMEOUT first -> status=0xE4, go to COLLECT.
- Latency: final byte sampled at edge E0; CHECK spans E0..E1; execute_task is high E1..E2 when job_done is already high.
- RPi_inst is held stable from latch until the next frame completes. It is never disturbed by a partial frame.
- Overrun: rx_valid in any state other than COLLECT drops the byte and sets overrun=1. overrun clears when the first byte of a new frame is accepted in COLLECT.
- Status holds its last code until the next event writes it. status becomes 0x00 when the first byte of a new frame is accepted.
- Reset asserted mid-operation: all state returns to reset values immediately; execute_task drops asynchronously.

Decomposition:
- Shared package rpi_accel_pkg holds:
  - the status code enum (status_t, 8-bit);
  - the receiver state enum (COLLECT, CHECK, HOLD, DISPATCH, WAIT_DONE);
  - the INST_WIDTH=80 constant, shared with task_manager.
- One natural sub-module: timeout_counter (parameterised limit, clear/enable inputs, expired output), instantiated twice: gap timer and done timer.

Test Plan:
1. Frame FF 00 00 00 00 00 00 00 00 2A, inst_valid=1, job_done=1 -> RPi_inst=0xFF00000000000000002A; single execute_task pulse 1 cycle after CHECK; status 0x01, then 0x02 after the job_done low->high sequence.
2. Frame starting 0x10, inst_valid=0 -> status=0xE1; no execute_task; busy back to 0 after 1 cycle.
3. Four bytes, then frame_active low -> status=0xE2, RPi_inst unchanged; a following full 10-byte frame is accepted normally.
4. Three bytes, then idle for 1024 cycles -> status=0xE3, byte_cnt=0; the next byte is treated as byte 0.
5. Valid frame with job_done=0 for 50 cycles -> stays in HOLD with no pulse; pulse within 1 cycle of job_done rising. Byte injected during WAIT_DONE -> overrun=1, byte dropped.
6. Assert reset_n=0 during WAIT_DONE -> all outputs return to reset values immediately, with no execute_task glitch after release.
